// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Control and sequencing front end for a 2-bit-minute / 6-bit-second stopwatch
// counter datapath. It does four jobs:
//   - conditions the raw start/stop/lap/clear buttons;
//   - runs the IDLE/RUN/PAUSE state machine;
//   - issues 1-cycle count_en and count_clr strobes to the counter;
//   - captures lap (split) times from the counter outputs.
//
// Parameters
//   TICK_DIV    clk cycles per counted second (>= 2)
//   DEB_CYCLES  consecutive stable synchronized samples needed to accept a
//               button level (>= 1)
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high; clears all state
//   start/stop/lap/clear  raw asynchronous buttons, active-high
//   cur_minute  counter minute value
//   cur_second  counter second value (0..59)
//   count_en    1-cycle strobe: counter advances one second
//   count_clr   1-cycle strobe: counter returns to 00:00
//   running     1 while state is RUN
//   state       0=IDLE 1=RUN 2=PAUSE (3 is unreachable and behaves as IDLE)
//   lap_min     captured minute
//   lap_sec     captured second
//   lap_hold    1 = display should show lap_min/lap_sec
//
// Build option
//   STOPWATCH_LAP_EN  When it is defined, the lap button and the lap
//                     registers are built. When it is undefined, the lap
//                     path is omitted and lap_min, lap_sec and lap_hold are
//                     tied to 0.
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       lap,
  input  logic       clear,
  input  logic [1:0] cur_minute,
  input  logic [5:0] cur_second,
  output logic       count_en,
  output logic       count_clr,
  output logic       running,
  output logic [1:0] state,
  output logic [1:0] lap_min,
  output logic [5:0] lap_sec,
  output logic       lap_hold
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DEB_CYCLES + 1);

  localparam int B_START = 0;
  localparam int B_STOP  = 1;
  localparam int B_CLEAR = 2;

`ifdef STOPWATCH_LAP_EN
  localparam int B_LAP = 3;
  localparam int NBTN  = 4;
`else
  localparam int NBTN  = 3;
`endif

  // ---------------------------------------------------------------------------
  // Button conditioning:
  //   2-flop synchronizer -> stability counter -> debounced level -> rise pulse.
  // The pulse appears DEB_CYCLES+3 edges after the first edge that samples a
  // new raw level.
  // ---------------------------------------------------------------------------
  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] btn_meta;
  logic [NBTN-1:0] btn_sync;
  logic [NBTN-1:0] btn_deb;
  logic [NBTN-1:0] btn_deb_q;
  logic [NBTN-1:0] btn_pulse;
  logic [CW-1:0]   deb_cnt [NBTN];

`ifdef STOPWATCH_LAP_EN
  assign btn_raw = {lap, clear, stop, start};
`else
  assign btn_raw = {clear, stop, start};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta  <= '0;
      btn_sync  <= '0;
      btn_deb   <= '0;
      btn_deb_q <= '0;
      btn_pulse <= '0;
      // NOTE: the counter array is reset explicitly. It is a handful of flops,
      // not a RAM, and the debounce must start from a known count after reset.
      for (int i = 0; i < NBTN; i++) deb_cnt[i] <= '0;
    end else begin
      // NOTE: every sequential update uses non-blocking assignment. This lets
      // btn_sync sample the old btn_meta, which forms the two-stage
      // synchronizer.
      btn_meta  <= btn_raw;
      btn_sync  <= btn_meta;
      btn_deb_q <= btn_deb;
      btn_pulse <= btn_deb & ~btn_deb_q;
      for (int i = 0; i < NBTN; i++) begin
        if (btn_sync[i] == btn_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
          // The count reaches DEB_CYCLES on this sample, so accept the level.
          btn_deb[i] <= btn_sync[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CW'(1);
        end
      end
    end
  end

  logic start_p, stop_p, clear_p, lap_p;
  assign start_p = btn_pulse[B_START];
  assign stop_p  = btn_pulse[B_STOP];
  assign clear_p = btn_pulse[B_CLEAR];
`ifdef STOPWATCH_LAP_EN
  assign lap_p = btn_pulse[B_LAP];
`else
  assign lap_p = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State machine and prescaler
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          count_en_d, count_clr_d;
  logic          tick;
  logic          lap_capture, lap_live, lap_wipe;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    presc_d     = presc_q;
    count_en_d  = 1'b0;
    count_clr_d = 1'b0;
    lap_capture = 1'b0;
    lap_live    = 1'b0;
    lap_wipe    = 1'b0;
    case (state_q)
      S_RUN: begin
        if (stop_p) begin
          // Stop masks a coincident tick and a coincident lap. The prescaler
          // keeps its value, so a resume keeps the sub-second fraction.
          state_d = S_PAUSE;
        end else begin
          presc_d     = tick ? '0 : presc_q + PW'(1);
          count_en_d  = tick;
          lap_capture = lap_p;
        end
      end
      S_PAUSE: begin
        if (clear_p) begin
          state_d     = S_IDLE;
          presc_d     = '0;
          count_clr_d = 1'b1;
          lap_wipe    = 1'b1;
        end else if (start_p) begin
          state_d = S_RUN;
        end else if (lap_p) begin
          lap_live = 1'b1;
        end
      end
      default: begin
        // IDLE, and the unused encoding 3, which behaves as IDLE.
        state_d = S_IDLE;
        presc_d = '0;
        if (clear_p) count_clr_d = 1'b1;
        else if (start_p) state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      count_en  <= 1'b0;
      count_clr <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      count_en  <= count_en_d;
      count_clr <= count_clr_d;
    end
  end

  assign state   = state_q;
  assign running = (state_q == S_RUN);

  // ---------------------------------------------------------------------------
  // Lap capture
  // ---------------------------------------------------------------------------
`ifdef STOPWATCH_LAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_min  <= '0;
      lap_sec  <= '0;
      lap_hold <= 1'b0;
    end else if (lap_wipe) begin
      lap_min  <= '0;
      lap_sec  <= '0;
      lap_hold <= 1'b0;
    end else if (lap_capture) begin
      lap_min  <= cur_minute;
      lap_sec  <= cur_second;
      lap_hold <= 1'b1;
    end else if (lap_live) begin
      lap_hold <= 1'b0;
    end
  end
`else
  assign lap_min  = '0;
  assign lap_sec  = '0;
  assign lap_hold = 1'b0;

  // These inputs keep the port list identical in both builds. Nothing
  // consumes them when the lap path is omitted.
  logic unused_lap;
  assign unused_lap = ^{lap, cur_minute, cur_second, lap_capture, lap_live, lap_wipe};
`endif

endmodule
